elixirchip_es1_spu_ctl_issue_seq: RTL
=====================================

// Module: elixirchip_es1_spu_ctl_issue_seq
//
// PURPOSE
//  Issue sequencer for an SPU op pipeline. After a start command it emits s_count
//  valid pulses, each followed by s_interval idle cycles, together with a gating
//  enable. It drives s_enable/s_valid of elixirchip_es1_spu_ctl_valid_en and the
//  op datapath. It then waits LATENCY cycles for the pipeline to drain and pulses done.
//
// PARAMETERS
//  COUNT_BITS     16                 width of issue count / index
//  INTERVAL_BITS  8                  width of inter-issue gap
//  LATENCY        3                  drain cycles after last issue (0..16 verified)
//  DEVICE         "RTL"              target device string, passed through
//  SIMULATION     "false"            simulation switch, passed through
//  DEBUG          "false"            debug switch, passed through
//
// PORTS
//  clk         in   1              clock
//  reset       in   1              synchronous, active-high reset
//  cke         in   1              clock enable; all state advances only when 1
//  s_start     in   1              start request (sampled in IDLE only)
//  s_count     in   COUNT_BITS     number of issues; 0 = none
//  s_interval  in   INTERVAL_BITS  idle cycles between issues; 0 = back-to-back
//  s_abort     in   1              stop issuing, drain, then finish
//  m_enable    out  1              issue window open (to valid_en s_enable)
//  m_valid     out  1              issue pulse (to valid_en s_valid)
//  m_first     out  1              current issue is index 0
//  m_last      out  1              current issue is index s_count-1
//  m_index     out  COUNT_BITS     index of current issue
//  m_busy      out  1              sequencer not IDLE
//  m_done      out  1              completion pulse
//
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset -> IDLE; all outputs 0,
//    counters 0. Reset mid-operation aborts immediately, with no done pulse.
//  - Outputs decode from registered state/counters only; no input-to-output comb path.
//  - Every register updates only on a cycle with cke=1. With cke=0 all state is
//    frozen and outputs hold their value (an asserted m_valid/m_done stays asserted).
//  - States: IDLE, ISSUE, GAP, DRAIN, DONE. m_busy=1 in every state except IDLE.
//  - IDLE: on s_start, latch s_count/s_interval and clear index. count==0 -> DONE;
//    else -> ISSUE. First m_valid appears 1 cycle after s_start is sampled.
//  - ISSUE: m_valid=1, m_enable=1, m_index=idx, m_first=(idx==0),
//    m_last=(idx==count-1).
//    * last issue -> DRAIN, drain counter = LATENCY; LATENCY==0 -> DONE.
//    * else idx++; interval==0 -> stay in ISSUE; else -> GAP, gap counter = interval.
//  - GAP: m_enable=1, m_valid=0. Counter decrements; at 1 -> ISSUE.
//  - DRAIN: m_enable=0, m_valid=0. Counter decrements; at 1 -> DONE.
//  - DONE: m_done=1 for exactly one cke cycle -> IDLE.
//  - m_first/m_last/m_index are meaningful only while m_valid=1; otherwise 0.
//  - s_start while busy: ignored (not queued).
//  - s_abort in ISSUE/GAP -> DRAIN (LATENCY cycles, or DONE if 0). An issue already
//    shown in that cycle counts; no further issues follow.
//  - s_abort in DRAIN/DONE: ignored. s_abort with s_start in IDLE: abort wins, stay IDLE.
//  - Count range 1..2^COUNT_BITS-1; the index never wraps (last compare ends first).
//
// TESTING  (cycle 0 = cycle in which s_start is sampled, cke=1 unless stated)
//  - count=3, interval=0, LATENCY=3 -> m_valid at 1,2,3 with index 0,1,2;
//    m_first@1, m_last@3; drain 4-6; m_done@7; m_busy 1..7.
//  - count=2, interval=2, LATENCY=3 -> m_valid@1,4; m_enable 1..4; m_done@8.
//  - count=0 -> no m_valid; m_done@1; m_busy@1 only.
//  - count=3, interval=0, cke=0 at cycle 2 -> index 1 held for 2 cycles;
//    m_done one cycle later (@8).
//  - count=4, interval=3, s_abort@2 (GAP), LATENCY=3 -> only m_valid@1;
//    DRAIN 3-5, m_done@6. Also: s_start while busy is ignored.
//  - reset@2 of a count=5 run -> IDLE; all outputs 0 @3; no m_done.
//    LATENCY sweep 0..16 with SVA: m_done exactly LATENCY+1 cycles after the last issue.

Source files
------------

// File: rtl/elixirchip_es1_spu_ctl_issue_seq_if.sv
// Issue-sequencer handshake bundle: start/abort command side (s_*) and
// issue/gating/completion side (m_*).
interface elixirchip_es1_spu_ctl_issue_seq_if #(
    parameter int COUNT_BITS    = 16,
    parameter int INTERVAL_BITS = 8
);
    logic                     s_start;
    logic [COUNT_BITS-1:0]    s_count;
    logic [INTERVAL_BITS-1:0] s_interval;
    logic                     s_abort;
    logic                     m_enable;
    logic                     m_valid;
    logic                     m_first;
    logic                     m_last;
    logic [COUNT_BITS-1:0]    m_index;
    logic                     m_busy;
    logic                     m_done;

    modport master (
        output s_start, s_count, s_interval, s_abort,
        input  m_enable, m_valid, m_first, m_last, m_index, m_busy, m_done
    );

    modport slave (
        input  s_start, s_count, s_interval, s_abort,
        output m_enable, m_valid, m_first, m_last, m_index, m_busy, m_done
    );
endinterface

// File: rtl/elixirchip_es1_spu_ctl_issue_seq.sv
// Issue sequencer: emits a counted train of valid pulses separated by idle gaps,
// waits for the op pipeline to drain, then pulses done.
module elixirchip_es1_spu_ctl_issue_seq #(
    parameter int    COUNT_BITS    = 16,
    parameter int    INTERVAL_BITS = 8,
    parameter int    LATENCY       = 3,
    parameter string DEVICE        = "RTL",
    parameter string SIMULATION    = "false",
    parameter string DEBUG         = "false"
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    elixirchip_es1_spu_ctl_issue_seq_if.slave bus
);
    localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic [COUNT_BITS-1:0]    cnt, cnt_nxt;
    logic [COUNT_BITS-1:0]    idx, idx_nxt;
    logic [INTERVAL_BITS-1:0] intv, intv_nxt;
    logic [INTERVAL_BITS-1:0] gap, gap_nxt;
    logic [LAT_W-1:0]         drn, drn_nxt;
    logic                     is_last;

    // cnt is never 0 while in ISSUE, so cnt-1 cannot underflow where it matters
    assign is_last = (idx == cnt - COUNT_BITS'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            intv  <= '0;
            gap   <= '0;
            drn   <= '0;
        end else if (cke) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            intv  <= intv_nxt;
            gap   <= gap_nxt;
            drn   <= drn_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        intv_nxt  = intv;
        gap_nxt   = gap;
        drn_nxt   = drn;
        case (state)
            IDLE: begin
                if (bus.s_start && !bus.s_abort) begin
                    cnt_nxt   = bus.s_count;
                    intv_nxt  = bus.s_interval;
                    idx_nxt   = '0;
                    state_nxt = (bus.s_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // the issue shown this cycle stands even when aborting
                if (bus.s_abort || is_last) begin
                    drn_nxt   = LAT_W'(LATENCY);
                    state_nxt = (LATENCY == 0) ? DONE : DRAIN;
                end else begin
                    idx_nxt = idx + COUNT_BITS'(1);
                    if (intv != '0) begin
                        gap_nxt   = intv;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (bus.s_abort) begin
                    drn_nxt   = LAT_W'(LATENCY);
                    state_nxt = (LATENCY == 0) ? DONE : DRAIN;
                end else if (gap == INTERVAL_BITS'(1)) begin
                    state_nxt = ISSUE;
                end else begin
                    gap_nxt = gap - INTERVAL_BITS'(1);
                end
            end
            DRAIN: begin
                if (drn == LAT_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    drn_nxt = drn - LAT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // outputs decode purely from registered state so cke=0 holds them as-is
    assign bus.m_valid  = (state == ISSUE);
    assign bus.m_enable = (state == ISSUE) || (state == GAP);
    assign bus.m_index  = (state == ISSUE) ? idx : '0;
    assign bus.m_first  = (state == ISSUE) && (idx == '0);
    assign bus.m_last   = (state == ISSUE) && is_last;
    assign bus.m_busy   = (state != IDLE);
    assign bus.m_done   = (state == DONE);
endmodule
